// File: rtl/tx_pattern_gen_utility_pkg.sv
// Shared definitions for the transmit training-pattern generator.
//   - pattern mode codes as seen on pattern_mode
//   - sequencer state encoding
//   - the 8'hAA preamble / clock-pattern word and the injection mask helper
package tx_pattern_gen_utility_pkg;

  localparam logic [2:0] MODE_FIXED = 3'd0;
  localparam logic [2:0] MODE_PRBS7 = 3'd1;
  localparam logic [2:0] MODE_COUNT = 3'd2;
  localparam logic [2:0] MODE_CLOCK = 3'd3;

  // Alternating 1/0 on the wire: every bit boundary is a transition.
  localparam logic [7:0] PREAMBLE_WORD = 8'hAA;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StRun,
    StDone
  } state_e;

  function automatic logic [7:0] flip_mask(input logic [2:0] sel);
    return 8'h01 << sel;
  endfunction

endpackage

// File: rtl/tx_pattern_gen_utility_prbs7.sv
// 8-bit parallel PRBS7 (x^7 + x^6 + 1) word generator.
//   clk160                     word clock
//   totalCounterResetb_manual  asynchronous active-low reset (state = PRBS_SEED)
//   load                       reload PRBS_SEED
//   advance                    step the LFSR by eight bits
//   word                       next word to send; bit 0 is the first serial bit
module prbs7_word_gen_utility #(
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic       clk160,
  input  logic       totalCounterResetb_manual,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] word
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [6:0] walk;

  // Eight serial steps unrolled; an all-zero state is treated as the seed so the
  // output never locks up even before the register itself is repaired.
  always_comb begin
    walk = (lfsr_q == 7'd0) ? PRBS_SEED : lfsr_q;
    word = 8'h00;
    for (int i = 0; i < 8; i++) begin
      word[i] = walk[6] ^ walk[5];
      walk    = {walk[5:0], word[i]};
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (load || (lfsr_q == 7'd0)) begin
      lfsr_d = PRBS_SEED;
    end else if (advance) begin
      lfsr_d = walk;
    end
  end

  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      lfsr_q <= PRBS_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/tx_pattern_gen_utility.sv
// Transmit-side training-pattern generator for the 8-bit clk160 link.
// Sends PREAMBLE_WORDS words of 8'hAA, then a selected pattern either
// continuously or for burst_len accepted words, with optional single-bit
// error injection.
//   clk160, totalCounterResetb_manual  clock / async active-low reset
//   enable            rising edge starts a sequence, low aborts
//   pattern_mode      0 fixed, 1 PRBS7, 2 counter, 3 clock, 4-7 PRBS7
//   fixed_word        word for mode 0 (tracked live)
//   burst_len         RUN words per sequence, 0 = continuous
//   tx_ready          serializer accepts a word this cycle
//   inject_error      slow-domain request, rising edge = one injection
//   inject_bit_sel    bit inverted on injection
//   tx_word/tx_valid  registered word to serializer
//   busy, done        sequencer active / one-cycle burst completion
//   word_counter, injected_counter  saturating statistics
module tx_pattern_gen_utility
  import tx_pattern_gen_utility_pkg::*;
#(
  parameter int unsigned PREAMBLE_WORDS = 32,
  parameter logic [6:0]  PRBS_SEED      = 7'h7F,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   clk160,
  input  logic                   totalCounterResetb_manual,
  input  logic                   enable,
  input  logic [2:0]             pattern_mode,
  input  logic [7:0]             fixed_word,
  input  logic [15:0]            burst_len,
  input  logic                   tx_ready,
  input  logic                   inject_error,
  input  logic [2:0]             inject_bit_sel,
  output logic [7:0]             tx_word,
  output logic                   tx_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] word_counter,
  output logic [COUNT_WIDTH-1:0] injected_counter
);

  localparam int unsigned PreCntW = $clog2(PREAMBLE_WORDS + 1);

  state_e                 state_q, state_d;
  logic                   enable_q;
  logic [2:0]             mode_q, mode_d;
  logic [15:0]            blen_q, blen_d;
  logic [PreCntW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [15:0]            run_cnt_q, run_cnt_d;
  logic [7:0]             count_pat_q, count_pat_d;
  logic [2:0]             sync_q;
  logic                   pending_q, pending_d;
  logic [7:0]             tx_word_q, tx_word_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [COUNT_WIDTH-1:0] inj_cnt_q, inj_cnt_d;

  logic       start;
  logic       accept;
  logic       inj_req;
  logic       prbs_load;
  logic [7:0] prbs_word;
  logic [7:0] pat_word;

  prbs7_word_gen_utility #(
    .PRBS_SEED(PRBS_SEED)
  ) u_prbs (
    .clk160                   (clk160),
    .totalCounterResetb_manual(totalCounterResetb_manual),
    .load                     (prbs_load),
    .advance                  (accept),
    .word                     (prbs_word)
  );

  assign start   = enable & ~enable_q;
  // Oldest two samples low, newest high: one request per slow-domain rising edge.
  assign inj_req = (sync_q == 3'b001);

  always_comb begin
    case (mode_q)
      MODE_FIXED: pat_word = fixed_word;
      MODE_COUNT: pat_word = count_pat_q;
      MODE_CLOCK: pat_word = PREAMBLE_WORD;
      default:    pat_word = prbs_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    blen_d      = blen_q;
    pre_cnt_d   = pre_cnt_q;
    run_cnt_d   = run_cnt_q;
    count_pat_d = count_pat_q;
    tx_word_d   = tx_word_q;
    tx_valid_d  = 1'b0;
    done_d      = 1'b0;
    prbs_load   = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_word_d = 8'h00;
        if (start) begin
          state_d     = StPreamble;
          mode_d      = pattern_mode;
          blen_d      = burst_len;
          pre_cnt_d   = '0;
          run_cnt_d   = 16'd0;
          count_pat_d = 8'h00;
          prbs_load   = 1'b1;
        end
      end
      StPreamble: begin
        if (!enable) begin
          state_d   = StIdle;
          tx_word_d = 8'h00;
        end else begin
          tx_word_d  = PREAMBLE_WORD;
          tx_valid_d = 1'b1;
          if (tx_ready) begin
            pre_cnt_d = pre_cnt_q + PreCntW'(1);
            if (pre_cnt_q == PreCntW'(PREAMBLE_WORDS - 1)) begin
              state_d = StRun;
            end
          end
        end
      end
      StRun: begin
        if (!enable) begin
          state_d   = StIdle;
          tx_word_d = 8'h00;
        end else begin
          tx_valid_d = 1'b1;
          // Stalled cycles leave tx_word and all generator state untouched.
          if (tx_ready) begin
            accept      = 1'b1;
            tx_word_d   = pending_q ? (pat_word ^ flip_mask(inject_bit_sel)) : pat_word;
            count_pat_d = count_pat_q + 8'd1;
            run_cnt_d   = run_cnt_q + 16'd1;
            if ((blen_q != 16'd0) && (run_cnt_q == blen_q - 16'd1)) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        tx_word_d = 8'h00;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
    endcase
  end

  // Injection bookkeeping and saturating statistics.
  always_comb begin
    pending_d  = pending_q;
    word_cnt_d = word_cnt_q;
    inj_cnt_d  = inj_cnt_q;
    if (state_q != StRun) begin
      pending_d = 1'b0;
    end else if (accept && pending_q) begin
      // A request arriving as the injected word goes out merges into it.
      pending_d = 1'b0;
    end else if (inj_req) begin
      pending_d = 1'b1;
    end
    if (accept && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + COUNT_WIDTH'(1);
    end
    if (accept && pending_q && (inj_cnt_q != '1)) begin
      inj_cnt_d = inj_cnt_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
    if (!totalCounterResetb_manual) begin
      state_q     <= StIdle;
      enable_q    <= 1'b0;
      mode_q      <= MODE_FIXED;
      blen_q      <= 16'd0;
      pre_cnt_q   <= '0;
      run_cnt_q   <= 16'd0;
      count_pat_q <= 8'h00;
      sync_q      <= 3'b000;
      pending_q   <= 1'b0;
      tx_word_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
      inj_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable;
      mode_q      <= mode_d;
      blen_q      <= blen_d;
      pre_cnt_q   <= pre_cnt_d;
      run_cnt_q   <= run_cnt_d;
      count_pat_q <= count_pat_d;
      sync_q      <= {sync_q[1:0], inject_error};
      pending_q   <= pending_d;
      tx_word_q   <= tx_word_d;
      tx_valid_q  <= tx_valid_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
      inj_cnt_q   <= inj_cnt_d;
    end
  end

  assign tx_word          = tx_word_q;
  assign tx_valid         = tx_valid_q;
  assign busy             = (state_q != StIdle);
  assign done             = done_q;
  assign word_counter     = word_cnt_q;
  assign injected_counter = inj_cnt_q;

endmodule

// File: tb/tb_tx_pattern_gen_utility.sv
// Bench for tx_pattern_gen_utility: drives inputs on the falling edge, samples
// 1 time unit after the rising edge, and compares the stream of accepted words
// against an expected stream built from the pattern rules.
module tb_tx_pattern_gen_utility;

  logic        clk160 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  pattern_mode;
  logic [7:0]  fixed_word;
  logic [15:0] burst_len;
  logic        tx_ready;
  logic        inject_error;
  logic [2:0]  inject_bit_sel;
  logic [7:0]  tx_word;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [31:0] word_counter;
  logic [31:0] injected_counter;
  logic [7:0]  sat_tx_word;
  logic        sat_tx_valid;
  logic        sat_busy;
  logic        sat_done;
  logic [3:0]  sat_word_counter;
  logic [3:0]  sat_injected_counter;

  always #5 clk160 = ~clk160;

  tx_pattern_gen_utility dut (
    .clk160                   (clk160),
    .totalCounterResetb_manual(rst_n),
    .enable                   (enable),
    .pattern_mode             (pattern_mode),
    .fixed_word               (fixed_word),
    .burst_len                (burst_len),
    .tx_ready                 (tx_ready),
    .inject_error             (inject_error),
    .inject_bit_sel           (inject_bit_sel),
    .tx_word                  (tx_word),
    .tx_valid                 (tx_valid),
    .busy                     (busy),
    .done                     (done),
    .word_counter             (word_counter),
    .injected_counter         (injected_counter)
  );

  tx_pattern_gen_utility #(
    .COUNT_WIDTH(4)
  ) dut_sat (
    .clk160                   (clk160),
    .totalCounterResetb_manual(rst_n),
    .enable                   (enable),
    .pattern_mode             (pattern_mode),
    .fixed_word               (fixed_word),
    .burst_len                (burst_len),
    .tx_ready                 (tx_ready),
    .inject_error             (inject_error),
    .inject_bit_sel           (inject_bit_sel),
    .tx_word                  (sat_tx_word),
    .tx_valid                 (sat_tx_valid),
    .busy                     (sat_busy),
    .done                     (sat_done),
    .word_counter             (sat_word_counter),
    .injected_counter         (sat_injected_counter)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference PRBS7 as a serial recurrence: seq[n] = seq[n-7] ^ seq[n-6],
  // history seeded with seven ones (oldest first); word j bit i = seq[7+8j+i].
  logic [7:0] prbs_ref[64];

  task automatic build_prbs_ref();
    bit seq[7 + 8 * 64];
    for (int n = 0; n < 7; n++) seq[n] = 1'b1;
    for (int n = 7; n < 7 + 8 * 64; n++) seq[n] = seq[n - 7] ^ seq[n - 6];
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 8; i++) prbs_ref[j][i] = seq[7 + 8 * j + i];
    end
  endtask

  // Monitor: a word counts as delivered when tx_valid follows a cycle with tx_ready.
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int unsigned done_cycles = 0;
  logic [7:0]  prev_word = 8'h00;
  logic        prev_valid = 1'b0;

  always @(posedge clk160) begin
    logic r;
    r = tx_ready;
    #1;
    if (tx_valid && r) got_q.push_back(tx_word);
    if (tx_valid && !r && prev_valid) check_eq("stall_hold", {24'h0, tx_word}, {24'h0, prev_word});
    if (done) begin
      done_cycles++;
      check_eq("done_without_valid", {31'h0, tx_valid}, 32'h0);
    end
    prev_word  = tx_word;
    prev_valid = tx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk160);
  endtask

  task automatic do_reset();
    @(negedge clk160);
    rst_n        = 1'b0;
    enable       = 1'b0;
    inject_error = 1'b0;
    tx_ready     = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    got_q.delete();
    done_cycles = 0;
  endtask

  task automatic start_seq(input logic [2:0] mode, input logic [15:0] blen);
    @(negedge clk160);
    pattern_mode = mode;
    burst_len    = blen;
    enable       = 1'b1;
  endtask

  task automatic run_until_idle(input bit toggle, input int max_cyc);
    int c;
    for (c = 0; c < max_cyc; c++) begin
      @(negedge clk160);
      if (toggle) tx_ready = ~tx_ready;
      if (c > 2 && !busy) break;
    end
    check_eq("idle_reached", {31'h0, (c < max_cyc)}, 32'h1);
  endtask

  task automatic expect_preamble();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'hAA);
  endtask

  task automatic compare_stream(input string tag, input int n, input bit exact);
    int unsigned e0;
    if (exact) check_eq({tag, "_len"}, got_q.size(), n);
    else       check_eq({tag, "_len_min"}, {31'h0, (got_q.size() >= n)}, 32'h1);
    e0 = n_errors;
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      if (n_errors != e0) break;
    end
  endtask

  task automatic pulse_inject(input int high, input int low);
    @(negedge clk160);
    inject_error = 1'b1;
    tick(high);
    inject_error = 1'b0;
    tick(low);
  endtask

  function automatic int count_val(input logic [7:0] v);
    int n = 0;
    foreach (got_q[i]) if (got_q[i] == v) n++;
    return n;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_ab;
    build_prbs_ref();
    rst_n          = 1'b0;
    enable         = 1'b0;
    pattern_mode   = 3'd0;
    fixed_word     = 8'h00;
    burst_len      = 16'd0;
    tx_ready       = 1'b1;
    inject_error   = 1'b0;
    inject_bit_sel = 3'd0;
    tick(2);
    check_eq("reset_outputs", {21'h0, tx_word, tx_valid, busy, done}, 32'h0);
    check_eq("reset_word_counter", word_counter, 32'h0);
    check_eq("reset_injected_counter", injected_counter, 32'h0);

    // PRBS7 continuous; mode/length changes after start must be ignored.
    do_reset();
    start_seq(3'd1, 16'd0);
    tick(1);
    pattern_mode = 3'd2;
    burst_len    = 16'd5;
    tick(45);
    expect_preamble();
    for (int j = 0; j < 12; j++) exp_q.push_back(prbs_ref[j]);
    check_eq("prbs_first_word_ref", {24'h0, prbs_ref[0]}, 32'h40);
    compare_stream("prbs", 44, 1'b0);
    check_eq("prbs_busy", {31'h0, busy}, 32'h1);
    check_eq("prbs_valid", {31'h0, tx_valid}, 32'h1);
    enable = 1'b0;
    tick(2);
    check_eq("prbs_stop_busy", {31'h0, busy}, 32'h0);
    check_eq("prbs_no_done", done_cycles, 32'h0);

    // Counter burst of 300 words.
    do_reset();
    start_seq(3'd2, 16'd300);
    run_until_idle(1'b0, 400);
    expect_preamble();
    for (int j = 0; j < 300; j++) exp_q.push_back(8'(j % 256));
    compare_stream("count", 332, 1'b1);
    check_eq("count_done_cycles", done_cycles, 32'd1);
    check_eq("count_word_counter", word_counter, 32'd300);
    check_eq("count_sat_word_counter", {28'h0, sat_word_counter}, 32'd15);
    tick(3);
    check_eq("count_no_restart", {31'h0, busy}, 32'h0);
    enable = 1'b0;

    // Fixed word, tx_ready toggling every cycle.
    do_reset();
    fixed_word = 8'h5A;
    start_seq(3'd0, 16'd10);
    run_until_idle(1'b1, 200);
    tx_ready = 1'b1;
    expect_preamble();
    for (int j = 0; j < 10; j++) exp_q.push_back(8'h5A);
    compare_stream("fixed", 42, 1'b1);
    check_eq("fixed_word_counter", word_counter, 32'd10);
    check_eq("fixed_done_cycles", done_cycles, 32'd1);
    enable = 1'b0;

    // Injection in clock mode; a request while idle is discarded.
    do_reset();
    inject_bit_sel = 3'd0;
    pulse_inject(3, 4);
    start_seq(3'd3, 16'd0);
    tick(40);
    check_eq("inj_idle_discard", injected_counter, 32'd0);
    got_q.delete();
    pulse_inject(3, 8);
    check_eq("inj_one_ab", count_val(8'hAB), 32'd1);
    check_eq("inj_rest_aa", count_val(8'hAA), got_q.size() - 1);
    check_eq("inj_counter_1", injected_counter, 32'd1);
    tx_ready = 1'b0;
    tick(2);
    pulse_inject(3, 6);
    check_eq("inj_stalled_counter", injected_counter, 32'd1);
    got_q.delete();
    tx_ready = 1'b1;
    tick(3);
    check_eq("inj_after_stall_len", {31'h0, (got_q.size() >= 1)}, 32'h1);
    if (got_q.size() >= 1) check_eq("inj_after_stall_word", {24'h0, got_q[0]}, 32'hAB);
    check_eq("inj_counter_2", injected_counter, 32'd2);
    for (int k = 0; k < 16; k++) pulse_inject(3, 4);
    n_ab = count_val(8'hAB);
    check_eq("inj_total_ab", n_ab, 32'd17);
    check_eq("inj_no_other", count_val(8'hAA) + n_ab, got_q.size());
    check_eq("inj_counter_18", injected_counter, 32'd18);
    check_eq("inj_sat_counter", {28'h0, sat_injected_counter}, 32'd15);
    check_eq("inj_sat_word_counter", {28'h0, sat_word_counter}, 32'd15);
    enable = 1'b0;

    // Abort mid-preamble, then restart from a fresh preamble and reseeded LFSR.
    do_reset();
    start_seq(3'd1, 16'd0);
    tick(10);
    enable = 1'b0;
    @(posedge clk160);
    #1;
    check_eq("abort_valid", {31'h0, tx_valid}, 32'h0);
    check_eq("abort_busy", {31'h0, busy}, 32'h0);
    tick(2);
    check_eq("abort_no_done", done_cycles, 32'h0);
    check_eq("abort_word_counter", word_counter, 32'h0);
    got_q.delete();
    enable = 1'b1;
    tick(42);
    expect_preamble();
    for (int j = 0; j < 8; j++) exp_q.push_back(prbs_ref[j]);
    compare_stream("restart", 40, 1'b0);
    enable = 1'b0;

    // Asynchronous reset mid-run clears outputs with no clock edge.
    do_reset();
    start_seq(3'd2, 16'd0);
    tick(50);
    check_eq("pre_reset_counting", {31'h0, (word_counter > 0)}, 32'h1);
    @(posedge clk160);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_outputs", {21'h0, tx_word, tx_valid, busy, done}, 32'h0);
    check_eq("async_word_counter", word_counter, 32'h0);
    check_eq("async_injected_counter", injected_counter, 32'h0);
    check_eq("async_sat_counters", {24'h0, sat_word_counter, sat_injected_counter}, 32'h0);
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_pattern_gen_utility.md
Name: tx_pattern_gen_utility

Overview:
Transmit-side training-pattern generator for the clk160 8-bit parallel link; feeds the serializer whose far end runs the delay-control error counter.
- Sends a transition-rich preamble, then a selectable pattern (fixed word, PRBS7, counter, clock) continuously or as a fixed-length burst.
- Supports single-bit error injection on request, for closed-loop checking of the receiver error counter.
- Bit 0 of each word is serialized first; bit 7 last.

Parameters:
PREAMBLE_WORDS, 32, words of 8'hAA sent before the pattern (exceeds the receiver's 16-transition wait)
PRBS_SEED, 7'h7F, PRBS7 LFSR load value on entering PREAMBLE; must be nonzero
COUNT_WIDTH, 32, width of the saturating statistics counters

Ports:
clk160  in  1  word clock
totalCounterResetb_manual  in  1  reset, asynchronous, active-low
enable  in  1  level; a rising edge starts a sequence; low aborts
pattern_mode  in  3  0 fixed, 1 PRBS7, 2 counter, 3 clock 8'hAA, 4-7 treated as PRBS7
fixed_word  in  8  word for mode 0
burst_len  in  16  RUN words per sequence; 0 = continuous
tx_ready  in  1  serializer accepts a word this cycle
inject_error  in  1  slow-domain request; a rising edge requests one injection
inject_bit_sel  in  3  bit index inverted on injection
tx_word  out  8  registered word to serializer
tx_valid  out  1  tx_word is meaningful (PREAMBLE or RUN)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at burst completion
word_counter  out  COUNT_WIDTH  RUN words accepted (tx_ready high), saturating
injected_counter  out  COUNT_WIDTH  injections actually applied, saturating

Behaviour:
- Reset: tx_word=0, tx_valid=0, busy=0, done=0, both counters=0, state=IDLE, LFSR=PRBS_SEED, counter pattern=0, sync shift registers=0.
- enable edge detect: register enable_d; start = enable & !enable_d.
- States: IDLE, PREAMBLE, RUN, DONE.
- IDLE → PREAMBLE on start. On that transition:
  - latch pattern_mode and burst_len (changes are ignored until the next start);
  - load LFSR=PRBS_SEED, counter pattern=0, preamble count=0.
- PREAMBLE:
  - tx_word=8'hAA, tx_valid=1.
  - Preamble count increments only on cycles with tx_ready.
  - After PREAMBLE_WORDS accepted words → RUN.
- RUN:
  - tx_word = pattern word, XOR (1<<inject_bit_sel) when an injection is pending.
  - The generator advances only when tx_ready=1. With tx_ready=0: tx_word holds, LFSR/counter do not step, nothing counts, the pending injection stays pending.
- Burst termination: burst_len≠0 and the burst_len-th word accepted → DONE.
- DONE: done=1 for exactly one cycle, tx_valid=0, → IDLE. A new run requires a fresh enable rising edge.
- enable low in PREAMBLE or RUN → IDLE next cycle, tx_valid=0, no done pulse. Counters keep their values.
- Output latency: registered; the word for state S appears one cycle after entering S.
- PRBS7 (x^7+x^6+1), per bit i=0..7:
  - b = s[6]^s[5]; s = {s[5:0], b}; word bit i = b.
  - If the LFSR is ever all-zero, reload PRBS_SEED.
- Counter mode: word value increments by 1 per accepted word, wraps 8'hFF→8'h00; first RUN word 8'h00.
- Fixed mode: tx_word tracks fixed_word live during RUN.
- Injection request path:
  - 3-stage SR on inject_error; the pattern 3'b001 sets pending.
  - Requests outside RUN are discarded.
  - A second request while pending is merged, not queued.
- Injection application: pending is cleared when the injected word is accepted; injected_counter +1 at the same time.
- Counters saturate at all-ones. They clear only on reset; the system merges the counter-reset request into totalCounterResetb_manual.
- Reset asserted mid-sequence: immediate return to the reset state.

Decomposition:
- Shared package holds the pattern mode constants (MODE_FIXED, MODE_PRBS7, MODE_COUNT, MODE_CLOCK), the state encoding, and the 8'hAA preamble/clock constant.
- One sub-module: prbs7_word_gen_utility, with inputs clk160, reset, load, advance; output word[7:0]. It performs the 8-bit parallel LFSR step including the zero-lock guard.

Test Plan:
- Reset, enable rise, tx_ready=1, mode 1, burst_len=0 → 32 words of 8'hAA, then PRBS words 8'h40, 8'h30, …; tx_valid=1 throughout.
- Mode 2, burst_len=300, tx_ready=1 →
  - words 00..FF, 00..2B;
  - done pulses once, 1 cycle;
  - word_counter=300; busy=0 afterwards.
- Mode 0, fixed_word=8'h5A, toggle tx_ready 1/0 each cycle, burst_len=10 →
  - 20 RUN cycles, word_counter=10;
  - tx_word stable across stall cycles.
- Mode 3 RUN, inject_error held high ≥3 cycles, inject_bit_sel=0 → exactly one word 8'hAB, injected_counter=1; a second pulse while tx_ready=0 is delayed until acceptance.
- Abort: drop enable mid-PREAMBLE → IDLE next cycle, no done, word_counter unchanged; a re-enable restarts the preamble from count 0 with the LFSR reseeded.
- Saturation/reset: force the counters near all-ones (COUNT_WIDTH override 4) → they stick at 15; asserting totalCounterResetb_manual low asynchronously clears all outputs without a clock edge.
